// File: rtl/exu_inst_queue_pkg.sv
// Shared EXU types: RV32I instruction word layout and the instruction-queue entry.
// Pure type/constant package; no ports, no logic.
// Imported by the instruction queue and its storage sub-module.

// Core register width; same value and guard as the ISA header so either may come first.
`ifndef RV_XLEN
`define RV_XLEN 32
`endif

package exu_inst_queue_pkg;

    // RV32I base instruction word (R-type field split; other formats overlay it).
    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } rv32i_inst_t;

    // One buffered fetch result: pc in the upper bits, instruction word below.
    typedef struct packed {
        logic [`RV_XLEN-1:0] pc;
        rv32i_inst_t         inst;
    } iq_entry_t;

    localparam int IQ_ENTRY_W = $bits(iq_entry_t);

endpackage

// File: rtl/exu_inst_queue_sync_fifo.sv
// Generic synchronous FIFO: WIDTH-bit entries, DEPTH (power of two, >= 2) slots.
// Ports: push/wdata in, pop/rdata out (head read combinationally), flush clears
// pointers and count, full/empty/count status from registered state only.

`ifndef RV_XLEN
`define RV_XLEN 32
`endif

module exu_inst_queue_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    // Requests are qualified by registered status only, so a pop in the same
    // cycle never frees a slot for a push into a full FIFO.
    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Pointers are exactly AW bits so they wrap DEPTH-1 -> 0 with no extra logic.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is never cleared; stale slots are unreachable once pointers reset.
    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wp] <= wdata;
    end

    assign rdata = mem[rp];
    assign count = cnt;

    a_cnt_bound: assert property (@(posedge clk) disable iff (rst) cnt <= CW'(DEPTH));
    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(do_push && full));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(do_pop && empty));

endmodule

// File: rtl/exu_inst_queue.sv
// Instruction queue between fetch and the EXU handlers: in-order buffer of {pc, inst}.
// Ports: in_vld/in_rdy/in_pc/in_inst from fetch; out_sel/out_pc/out_inst/out_done to
// the handlers; flush drops every entry; count reports occupancy. Head visible 1 cycle after push.

`ifndef RV_XLEN
`define RV_XLEN 32
`endif

module exu_inst_queue
    import exu_inst_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_vld,
    output logic                in_rdy,
    input  logic [`RV_XLEN-1:0] in_pc,
    input  rv32i_inst_t         in_inst,
    output logic                out_sel,
    output logic [`RV_XLEN-1:0] out_pc,
    output rv32i_inst_t         out_inst,
    input  logic                out_done,
    output logic [CW-1:0]       count
);

    iq_entry_t in_entry;
    iq_entry_t head;
    logic      full;
    logic      empty;

    assign in_entry.pc   = in_pc;
    assign in_entry.inst = in_inst;

    // The FIFO gates push with !full and pop with !empty internally, so
    // out_done while nothing is selected is harmless.
    exu_inst_queue_sync_fifo #(
        .WIDTH (IQ_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (in_vld),
        .wdata (in_entry),
        .pop   (out_done),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign in_rdy   = !full;
    assign out_sel  = !empty;
    assign out_pc   = head.pc;
    assign out_inst = head.inst;

endmodule
